// File: rtl/shift_issue_stage.sv
// Decode/issue stage feeding the shifter ALU: decodes R-type shifts and holds them in a 2-entry skid buffer.
// Optional: define SHIFT_ILLEGAL_STICKY_EN to add the sticky illegal_seen output.
module shift_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand,
  output logic [AMT_W-1:0]  sh_amt,
  output logic [AMT_W-1:0]  v_sh_amt,
  output logic [1:0]        cont_sig,
  output logic              cont_sig1,
  output logic [4:0]        out_rd,
  output logic              out_illegal
`ifdef SHIFT_ILLEGAL_STICKY_EN
  ,
  output logic              illegal_seen
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [AMT_W-1:0]  sh_amt;
    logic [AMT_W-1:0]  v_sh_amt;
    logic [1:0]        cont_sig;
    logic              cont_sig1;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t dec;
  entry_t head;
  entry_t skid;
  logic   legal;
  logic   push;
  logic   pop;
  logic   unused_bits;

  assign unused_bits = ^{in_instr[25:16], in_rs_val[DATA_W-1:AMT_W]};

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Operands are captured even for illegal encodings; only the controls are forced.
  always_comb begin
    dec           = '0;
    dec.operand   = in_rt_val;
    dec.sh_amt    = in_instr[6 +: AMT_W];
    dec.v_sh_amt  = in_rs_val[AMT_W-1:0];
    legal         = (in_instr[31:26] == 6'b000000);
    unique case (in_instr[5:0])
      6'b000000: begin dec.cont_sig = 2'b00; dec.cont_sig1 = 1'b0; end
      6'b000010: begin dec.cont_sig = 2'b01; dec.cont_sig1 = 1'b0; end
      6'b000011: begin dec.cont_sig = 2'b11; dec.cont_sig1 = 1'b0; end
      6'b000100: begin dec.cont_sig = 2'b00; dec.cont_sig1 = 1'b1; end
      6'b000110: begin dec.cont_sig = 2'b01; dec.cont_sig1 = 1'b1; end
      6'b000111: begin dec.cont_sig = 2'b11; dec.cont_sig1 = 1'b1; end
      default:   legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd      = in_instr[15:11];
      dec.illegal = 1'b0;
    end else begin
      dec.cont_sig  = 2'b10;
      dec.cont_sig1 = 1'b0;
      dec.rd        = '0;
      dec.illegal   = 1'b1;
    end
  end

  // out_valid and in_ready are registered copies of (state != EMPTY) and (state != FULL).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            skid     <= dec;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head     <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SHIFT_ILLEGAL_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_seen <= 1'b0;
    end else if (pop && head.illegal) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

  assign operand     = head.operand;
  assign sh_amt      = head.sh_amt;
  assign v_sh_amt    = head.v_sh_amt;
  assign cont_sig    = head.cont_sig;
  assign cont_sig1   = head.cont_sig1;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage (also covers SHIFT_ILLEGAL_STICKY_EN when defined).
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand;
  logic [4:0]  sh_amt;
  logic [4:0]  v_sh_amt;
  logic [1:0]  cont_sig;
  logic        cont_sig1;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef SHIFT_ILLEGAL_STICKY_EN
  logic        illegal_seen;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  shift_issue_stage #(.DATA_W(32), .AMT_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand(operand), .sh_amt(sh_amt), .v_sh_amt(v_sh_amt),
    .cont_sig(cont_sig), .cont_sig1(cont_sig1), .out_rd(out_rd),
    .out_illegal(out_illegal)
`ifdef SHIFT_ILLEGAL_STICKY_EN
    , .illegal_seen(illegal_seen)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt);
    in_valid  = v;
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
  endtask

  task automatic check_zero_payload(input string tag);
    check({tag, "_operand"}, operand, 32'h0);
    check({tag, "_sh_amt"}, 32'(sh_amt), 32'h0);
    check({tag, "_v_sh_amt"}, 32'(v_sh_amt), 32'h0);
    check({tag, "_cont_sig"}, 32'(cont_sig), 32'h0);
    check({tag, "_cont_sig1"}, 32'(cont_sig1), 32'h0);
    check({tag, "_rd"}, 32'(out_rd), 32'h0);
    check({tag, "_illegal"}, 32'(out_illegal), 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check_zero_payload("rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tick();

    // SLL $8, $rt, 4
    out_ready = 1'b1;
    offer(1'b1, 32'h0008_4100, 32'h0, 32'h0000_0001);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("sll_valid", 32'(out_valid), 32'h1);
    check("sll_cont_sig", 32'(cont_sig), 32'h0);
    check("sll_cont_sig1", 32'(cont_sig1), 32'h0);
    check("sll_sh_amt", 32'(sh_amt), 32'h4);
    check("sll_rd", 32'(out_rd), 32'h8);
    check("sll_operand", operand, 32'h0000_0001);
    check("sll_illegal", 32'(out_illegal), 32'h0);
    tick();
    check("sll_popped", 32'(out_valid), 32'h0);

    // SRAV $2, rt, rs ; head must hold while out_ready is low
    out_ready = 1'b0;
    offer(1'b1, 32'h0064_1007, 32'hFFFF_FFE3, 32'h8000_0000);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("srav_valid", 32'(out_valid), 32'h1);
    check("srav_cont_sig", 32'(cont_sig), 32'h3);
    check("srav_cont_sig1", 32'(cont_sig1), 32'h1);
    check("srav_v_sh_amt", 32'(v_sh_amt), 32'h3);
    check("srav_rd", 32'(out_rd), 32'h2);
    check("srav_operand", operand, 32'h8000_0000);
    check("srav_illegal", 32'(out_illegal), 32'h0);
    out_ready = 1'b1;
    tick();
    check("srav_popped", 32'(out_valid), 32'h0);

    // Illegal funct 000001: operands still captured
    out_ready = 1'b0;
    offer(1'b1, 32'h0000_0001, 32'h0000_0005, 32'h0000_1234);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("ill_cont_sig", 32'(cont_sig), 32'h2);
    check("ill_cont_sig1", 32'(cont_sig1), 32'h0);
    check("ill_rd", 32'(out_rd), 32'h0);
    check("ill_illegal", 32'(out_illegal), 32'h1);
    check("ill_operand", operand, 32'h0000_1234);
    check("ill_v_sh_amt", 32'(v_sh_amt), 32'h5);
`ifdef SHIFT_ILLEGAL_STICKY_EN
    check("sticky_before_pop", 32'(illegal_seen), 32'h0);
`endif
    out_ready = 1'b1;
    tick();
    check("ill_popped", 32'(out_valid), 32'h0);
`ifdef SHIFT_ILLEGAL_STICKY_EN
    check("sticky_after_pop", 32'(illegal_seen), 32'h1);
`endif

    // Illegal opcode with a legal funct/rd: rd forced to 0, shamt kept
    out_ready = 1'b0;
    offer(1'b1, 32'h0808_4100, 32'h0, 32'h0000_00AA);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("illop_illegal", 32'(out_illegal), 32'h1);
    check("illop_rd", 32'(out_rd), 32'h0);
    check("illop_sh_amt", 32'(sh_amt), 32'h4);
    check("illop_cont_sig", 32'(cont_sig), 32'h2);
    out_ready = 1'b1;
    tick();

    // Backpressure: A, B accepted, C held off until B pops
    out_ready = 1'b0;
    offer(1'b1, 32'h0000_0002, 32'h0, 32'h0000_000A);
    tick();
    check("bp_a_ready", 32'(in_ready), 32'h1);
    offer(1'b1, 32'h0000_0002, 32'h0, 32'h0000_000B);
    tick();
    check("bp_full_ready", 32'(in_ready), 32'h0);
    check("bp_head_a", operand, 32'h0000_000A);
    offer(1'b1, 32'h0000_0002, 32'h0, 32'h0000_000C);
    tick();
    check("bp_still_full", 32'(in_ready), 32'h0);
    check("bp_head_a_stable", operand, 32'h0000_000A);
    check("bp_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    check("bp_head_b", operand, 32'h0000_000B);
    check("bp_ready_again", 32'(in_ready), 32'h1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("bp_head_c", operand, 32'h0000_000C);
    check("bp_c_valid", 32'(out_valid), 32'h1);
    tick();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Push with pop at count 1, then flush with a concurrent push
    offer(1'b1, 32'h0000_0000, 32'h0, 32'h0000_000D);
    tick();
    offer(1'b1, 32'h0000_0000, 32'h0, 32'h0000_000E);
    tick();
    check("pp_head_e", operand, 32'h0000_000E);
    check("pp_valid", 32'(out_valid), 32'h1);
    check("pp_ready", 32'(in_ready), 32'h1);
    flush = 1'b1;
    offer(1'b1, 32'h0000_0000, 32'h0, 32'h0000_000F);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_ready", 32'(in_ready), 32'h1);
    tick();
    check("flush_dropped", 32'(out_valid), 32'h0);

    // Async reset with two entries buffered, head illegal
    out_ready = 1'b0;
    offer(1'b1, 32'h0000_003F, 32'h0000_001F, 32'h0000_0011);
    tick();
    offer(1'b1, 32'h0000_0002, 32'h0, 32'h0000_0022);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("pre_rst_full", 32'(in_ready), 32'h0);
    check("pre_rst_illegal", 32'(out_illegal), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    check_zero_payload("arst");
`ifdef SHIFT_ILLEGAL_STICKY_EN
    check("arst_sticky", 32'(illegal_seen), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // NOP (SLL $0) is a legal instruction
    offer(1'b1, 32'h0000_0000, 32'h0, 32'h0000_0077);
    tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0);
    check("nop_valid", 32'(out_valid), 32'h1);
    check("nop_illegal", 32'(out_illegal), 32'h0);
    check("nop_operand", operand, 32'h0000_0077);
    check("nop_cont_sig", 32'(cont_sig), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
